// File: rtl/alu_uart_master.sv
// Host-side UART initiator for the ALU link: sends A, B, OP as three 8N1 frames, then receives one result frame.
// Define ALU_UART_TIMEOUT_EN to build the result-wait timeout; otherwise o_timeout is tied low.
module alu_uart_master #(
  parameter int DBIT          = 8,
  parameter int NB_OP         = 6,
  parameter int SB_TICK       = 16,
  parameter int TIMEOUT_TICKS = 16384,
  parameter int TO_BITS       = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_s_tick,
  input  logic             i_start,
  input  logic [DBIT-1:0]  i_data_a,
  input  logic [DBIT-1:0]  i_data_b,
  input  logic [NB_OP-1:0] i_operation,
  input  logic             i_rx,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [DBIT-1:0]  o_result,
  output logic             o_timeout
);

  localparam int              BC_W      = $clog2(DBIT + 1);
  localparam logic [5:0]      HALF_LAST = 6'd7;
  localparam logic [5:0]      BIT_LAST  = 6'd15;
  localparam logic [5:0]      STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DBIT - 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
  } state_t;

  state_t          state;
  logic [5:0]      tick_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic [1:0]      byte_idx;
  logic [DBIT-1:0] b_reg;
  logic [DBIT-1:0] op_reg;
  logic [DBIT-1:0] tx_shift;
  logic [DBIT-1:0] rx_shift;
  logic            rx_meta;
  logic            rx_sync;

`ifdef ALU_UART_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_TICKS - 1);
  logic [TO_BITS-1:0] to_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
`ifdef ALU_UART_TIMEOUT_EN
      to_cnt    <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            tx_shift <= i_data_a;
            b_reg    <= i_data_b;
            op_reg   <= DBIT'(i_operation);
            byte_idx <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (i_s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              o_tx     <= tx_shift[0];
              state    <= TX_DATA;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        TX_DATA: begin
          if (i_s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
                o_tx  <= 1'b1;
                state <= TX_STOP;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                tx_shift <= tx_shift >> 1;
                o_tx     <= tx_shift[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        // The next frame's start bit begins directly at the end of this stop bit
        TX_STOP: begin
          if (i_s_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              if (byte_idx != 2'd2) begin
                byte_idx <= byte_idx + 2'd1;
                tx_shift <= (byte_idx == 2'd0) ? b_reg : op_reg;
                o_tx     <= 1'b0;
                state    <= TX_START;
              end else begin
`ifdef ALU_UART_TIMEOUT_EN
                to_cnt <= '0;
`endif
                state <= RX_WAIT;
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        RX_WAIT: begin
          if (!rx_sync) begin
            tick_cnt <= '0;
            state    <= RX_START;
          end
`ifdef ALU_UART_TIMEOUT_EN
          else if (i_s_tick) begin
            if (to_cnt == TO_LAST) begin
              o_done    <= 1'b1;
              o_timeout <= 1'b1;
              state     <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
`endif
        end
        // Mid-start-bit recheck rejects short glitches
        RX_START: begin
          if (i_s_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_sync) begin
                bit_cnt <= '0;
                state   <= RX_DATA;
              end else begin
                state <= RX_WAIT;
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        RX_DATA: begin
          if (i_s_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              rx_shift <= {rx_sync, rx_shift[DBIT-1:1]};
              if (bit_cnt == DATA_LAST) begin
                state <= RX_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        RX_STOP: begin
          if (i_s_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              o_result <= rx_shift;
              o_done   <= 1'b1;
`ifdef ALU_UART_TIMEOUT_EN
              o_timeout <= 1'b0;
`endif
              state <= DONE;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_master.sv
// Randomized bench for alu_uart_master with a device-side UART/ALU model.
// Frames on o_tx are decoded by bit-centre sampling; replies are driven on i_rx.
`timescale 1ns/1ps
module tb_alu_uart_master;

  localparam int DBIT          = 8;
  localparam int NB_OP         = 6;
  localparam int SB_TICK       = 16;
  localparam int TIMEOUT_TICKS = 64;
  localparam int TO_BITS       = 7;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_s_tick = 1'b1;
  logic             i_start = 1'b0;
  logic [DBIT-1:0]  i_data_a = '0;
  logic [DBIT-1:0]  i_data_b = '0;
  logic [NB_OP-1:0] i_operation = '0;
  logic             i_rx = 1'b1;
  logic             o_tx;
  logic             o_busy;
  logic             o_done;
  logic [DBIT-1:0]  o_result;
  logic             o_timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_div = 1;
  int tick_phase = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic [7:0] done_result = '0;
  logic       done_timeout = 1'b0;
  logic [7:0] last_good = '0;

  logic [7:0] fr_got [3];
  int         fr_fall [3];
  bit         fr_ok [3];

  alu_uart_master #(
    .DBIT(DBIT), .NB_OP(NB_OP), .SB_TICK(SB_TICK),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .TO_BITS(TO_BITS)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_s_tick(i_s_tick), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_operation(i_operation),
    .i_rx(i_rx), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    tick_phase = (tick_phase + 1) % tick_div;
    i_s_tick = (tick_phase == 0);
  end

  always @(negedge i_clk) begin
    if (o_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
      done_result = o_result;
      done_timeout = o_timeout;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog sim time exceeded total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Device-side ALU reference
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h02: return a >> b[2:0];
      6'h03: return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_data_a = a;
    i_data_b = b;
    i_operation = op;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic capture_frame(input int idx);
    int p;
    int n;
    logic [7:0] d;
    p = 16 * tick_div;
    n = 0;
    d = '0;
    fr_ok[idx] = 1'b0;
    fr_fall[idx] = -1;
    while (o_tx !== 1'b0 && n < 4000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_tx === 1'b0) begin
      fr_fall[idx] = cyc;
      repeat (p / 2) @(negedge i_clk);
      fr_ok[idx] = (o_tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (p) @(negedge i_clk);
        d[i] = o_tx;
      end
      repeat (p) @(negedge i_clk);
      fr_ok[idx] = fr_ok[idx] && (o_tx === 1'b1);
    end
    fr_got[idx] = d;
  endtask

  task automatic capture_three();
    for (int i = 0; i < 3; i++) capture_frame(i);
  endtask

  task automatic send_frame(input logic [7:0] d);
    int p;
    p = 16 * tick_div;
    i_rx = 1'b0;
    repeat (p) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (p) @(negedge i_clk);
    end
    i_rx = 1'b1;
    repeat (p) @(negedge i_clk);
  endtask

  task automatic wait_done(input int base, input int limit, output bit seen);
    int n;
    n = 0;
    while (done_count == base && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    seen = (done_count != base);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00 || o_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_values got tx=%b busy=%b done=%b res=%02h to=%b exp 1 0 0 00 0",
               o_tx, o_busy, o_done, o_result, o_timeout);
    end
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got tx=%b busy=%b exp 1 0", o_tx, o_busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_fr [3];
    logic [7:0] exp_res;
    int base;
    bit seen;
    tick_div = 1;
    base = done_count;
    exp_fr = '{8'h05, 8'h03, 8'h20};
    exp_res = alu_ref(8'h05, 8'h03, 6'h20);
    issue_cmd(8'h05, 8'h03, 6'h20);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_busy_high got=%b exp=1", o_busy);
    end
    capture_three();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (!fr_ok[i] || fr_got[i] !== exp_fr[i]) begin
        bad++;
        $display("[TB] FAIL basic_frame%0d got=%02h ok=%0b exp=%02h", i, fr_got[i], fr_ok[i], exp_fr[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (fr_fall[i] - fr_fall[i-1] != 160) begin
        bad++;
        $display("[TB] FAIL basic_frame_len%0d got=%0d exp=160", i, fr_fall[i] - fr_fall[i-1]);
      end
    end
    repeat (10) @(negedge i_clk);
    send_frame(exp_res);
    wait_done(base, 400, seen);
    repeat (5) @(negedge i_clk);
    total++;
    if (!seen || done_count != base + 1) begin
      bad++;
      $display("[TB] FAIL basic_done_count got=%0d exp=%0d", done_count - base, 1);
    end
    total++;
    if (done_result !== exp_res || o_result !== exp_res) begin
      bad++;
      $display("[TB] FAIL basic_result got=%02h held=%02h exp=%02h", done_result, o_result, exp_res);
    end
    total++;
    if (done_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_timeout got=%b exp=0", done_timeout);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_busy_after got=%b exp=0", o_busy);
    end
    last_good = exp_res;
  endtask

  task automatic test_timeout();
    int base;
    bit seen;
    tick_div = 1;
    base = done_count;
    issue_cmd(8'h11, 8'h22, 6'h24);
    capture_three();
    total++;
    if (!fr_ok[2] || fr_got[2] !== 8'h24) begin
      bad++;
      $display("[TB] FAIL timeout_op_frame got=%02h ok=%0b exp=24", fr_got[2], fr_ok[2]);
    end
`ifdef ALU_UART_TIMEOUT_EN
    wait_done(base, 600, seen);
    repeat (3) @(negedge i_clk);
    total++;
    if (!seen || done_timeout !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_flag got seen=%0b to=%b exp seen=1 to=1", seen, done_timeout);
    end
    total++;
    if (done_result !== last_good) begin
      bad++;
      $display("[TB] FAIL timeout_result_kept got=%02h exp=%02h", done_result, last_good);
    end
    total++;
    if (done_cyc - fr_fall[2] != 160 + TIMEOUT_TICKS) begin
      bad++;
      $display("[TB] FAIL timeout_latency got=%0d exp=%0d", done_cyc - fr_fall[2], 160 + TIMEOUT_TICKS);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_busy_after got=%b exp=0", o_busy);
    end
`else
    repeat (600) @(negedge i_clk);
    total++;
    if (done_count != base || o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wait_forever got dones=%0d busy=%b exp dones=0 busy=1", done_count - base, o_busy);
    end
    send_frame(8'h3C);
    wait_done(base, 400, seen);
    repeat (3) @(negedge i_clk);
    total++;
    if (!seen || done_result !== 8'h3C || done_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL late_reply got seen=%0b res=%02h to=%b exp seen=1 res=3c to=0",
               seen, done_result, done_timeout);
    end
    last_good = 8'h3C;
`endif
  endtask

  task automatic test_ignored_start();
    logic [7:0] a, b;
    logic [5:0] op;
    logic [7:0] exp_fr [3];
    logic [7:0] exp_res;
    int base;
    int lows;
    bit seen;
    tick_div = 1;
    a = 8'($urandom_range(0, 254));
    b = 8'($urandom);
    op = 6'h26;
    exp_fr = '{a, b, {2'b00, op}};
    exp_res = alu_ref(a, b, op);
    base = done_count;
    issue_cmd(a, b, op);
    fork
      capture_three();
      begin
        repeat (49) @(negedge i_clk);
        i_data_a = 8'hFF;
        i_data_b = ~b;
        i_operation = 6'h20;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) begin
      total++;
      if (!fr_ok[i] || fr_got[i] !== exp_fr[i]) begin
        bad++;
        $display("[TB] FAIL ignore_frame%0d got=%02h ok=%0b exp=%02h", i, fr_got[i], fr_ok[i], exp_fr[i]);
      end
    end
    repeat (10) @(negedge i_clk);
    send_frame(exp_res);
    wait_done(base, 400, seen);
    lows = 0;
    repeat (200) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
    total++;
    if (done_count != base + 1 || done_result !== exp_res) begin
      bad++;
      $display("[TB] FAIL ignore_done got dones=%0d res=%02h exp dones=1 res=%02h",
               done_count - base, done_result, exp_res);
    end
    total++;
    if (lows != 0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ignore_idle_after got lows=%0d busy=%b exp 0 0", lows, o_busy);
    end
    last_good = exp_res;
  endtask

  task automatic test_glitch();
    int base;
    bit seen;
    tick_div = 1;
    base = done_count;
    issue_cmd(8'h9C, 8'h41, 6'h25);
    capture_three();
    repeat (10) @(negedge i_clk);
    i_rx = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (20) @(negedge i_clk);
    send_frame(8'hA5);
    wait_done(base, 400, seen);
    repeat (3) @(negedge i_clk);
    total++;
    if (!seen || done_count != base + 1) begin
      bad++;
      $display("[TB] FAIL glitch_done_count got=%0d exp=1", done_count - base);
    end
    total++;
    if (done_result !== 8'hA5 || done_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL glitch_result got=%02h to=%b exp=a5 to=0", done_result, done_timeout);
    end
    last_good = 8'hA5;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_res;
    int base;
    int lows;
    bit seen;
    tick_div = 1;
    issue_cmd(8'h33, 8'h0F, 6'h24);
    capture_frame(0);
    repeat (48) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    total++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00) begin
      bad++;
      $display("[TB] FAIL midreset_immediate got tx=%b busy=%b done=%b res=%02h exp 1 0 0 00",
               o_tx, o_busy, o_done, o_result);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    last_good = 8'h00;
    lows = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("[TB] FAIL midreset_stays_idle got=%0d bad cycles exp=0", lows);
    end
    base = done_count;
    exp_res = alu_ref(8'hC4, 8'h3A, 6'h20);
    issue_cmd(8'hC4, 8'h3A, 6'h20);
    capture_three();
    total++;
    if (!fr_ok[0] || !fr_ok[1] || !fr_ok[2] || fr_got[0] !== 8'hC4 || fr_got[1] !== 8'h3A || fr_got[2] !== 8'h20) begin
      bad++;
      $display("[TB] FAIL midreset_frames got=%02h %02h %02h exp=c4 3a 20", fr_got[0], fr_got[1], fr_got[2]);
    end
    repeat (10) @(negedge i_clk);
    send_frame(exp_res);
    wait_done(base, 400, seen);
    repeat (3) @(negedge i_clk);
    total++;
    if (!seen || done_result !== exp_res || done_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_result got=%02h to=%b exp=%02h to=0", done_result, done_timeout, exp_res);
    end
    last_good = exp_res;
  endtask

  task automatic test_slow_tick();
    logic [7:0] exp_res;
    int base;
    bit seen;
    tick_div = 4;
    repeat (8) @(negedge i_clk);
    base = done_count;
    exp_res = alu_ref(8'h80, 8'h01, 6'h22);
    issue_cmd(8'h80, 8'h01, 6'h22);
    capture_three();
    total++;
    if (!fr_ok[0] || !fr_ok[1] || !fr_ok[2] || fr_got[0] !== 8'h80 || fr_got[1] !== 8'h01 || fr_got[2] !== 8'h22) begin
      bad++;
      $display("[TB] FAIL slow_frames got=%02h %02h %02h exp=80 01 22", fr_got[0], fr_got[1], fr_got[2]);
    end
    total++;
    if (fr_fall[2] - fr_fall[1] != 640) begin
      bad++;
      $display("[TB] FAIL slow_frame_len got=%0d exp=640", fr_fall[2] - fr_fall[1]);
    end
    repeat (34) @(negedge i_clk);
    send_frame(exp_res);
    wait_done(base, 1500, seen);
    repeat (3) @(negedge i_clk);
    total++;
    if (!seen || done_result !== exp_res || done_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL slow_result got=%02h to=%b exp=%02h to=0", done_result, done_timeout, exp_res);
    end
    last_good = exp_res;
    tick_div = 1;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [7:0] a, b, exp_res;
    logic [5:0] op;
    logic [7:0] exp_fr [3];
    int base;
    bit seen;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    for (int t = 0; t < 4; t++) begin
      tick_div = int'($urandom_range(1, 3));
      repeat (6) @(negedge i_clk);
      a = 8'($urandom);
      b = 8'($urandom);
      op = ops[$urandom_range(0, 7)];
      exp_fr = '{a, b, {2'b00, op}};
      exp_res = alu_ref(a, b, op);
      base = done_count;
      issue_cmd(a, b, op);
      capture_three();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (!fr_ok[i] || fr_got[i] !== exp_fr[i]) begin
          bad++;
          $display("[TB] FAIL rand%0d_frame%0d got=%02h ok=%0b exp=%02h", t, i, fr_got[i], fr_ok[i], exp_fr[i]);
        end
      end
      repeat (8 * tick_div + 2) @(negedge i_clk);
      send_frame(exp_res);
      wait_done(base, 400 * tick_div, seen);
      repeat (3) @(negedge i_clk);
      total++;
      if (!seen || done_count != base + 1 || done_result !== exp_res || done_timeout !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand%0d_result got=%02h dones=%0d to=%b exp=%02h dones=1 to=0",
                 t, done_result, done_count - base, done_timeout, exp_res);
      end
      last_good = exp_res;
    end
    tick_div = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_ignored_start();
    test_glitch();
    test_reset_mid();
    test_slow_tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_master.md
Name: alu_uart_master

Overview:
- Host-side initiator for the UART ALU link; the opposite end of the receive/ALU/transmit device.
- Takes one ALU command (A, B, operation) on a parallel valid/busy handshake.
- Serializes it as three 8N1-style UART frames, then deserializes the single result frame returned by the device.
- Presents the result in parallel. Shares the baud-rate generator tick (16x oversampling) with the rest of the design; used in benches and board-to-board loopback.

Parameters:
DBIT, 8, data bits per frame (operands, result, padded operation)
NB_OP, 6, operation code width; NB_OP <= DBIT
SB_TICK, 16, s_ticks spent in stop bit, both directions (16/24/32)
TIMEOUT_TICKS, 16384, s_ticks allowed for the result start bit (only with ALU_UART_TIMEOUT_EN)
TO_BITS, 15, counter width for TIMEOUT_TICKS

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_s_tick  in  1  baud tick, 16 per bit, one i_clk wide
i_start  in  1  command request, sampled only when o_busy=0
i_data_a  in  DBIT  operand A
i_data_b  in  DBIT  operand B
i_operation  in  NB_OP  ALU opcode
i_rx  in  1  serial line from device (device TX)
o_tx  out  1  serial line to device (device RX)
o_busy  out  1  command in flight
o_done  out  1  one-cycle pulse, transaction finished
o_result  out  DBIT  received result, held until next o_done
o_timeout  out  1  valid with o_done; 1 = no result received

Behaviour:
- Reset values (immediate, asynchronous): o_tx=1, o_busy=0, o_done=0, o_result=0, o_timeout=0. All counters 0, FSM=IDLE.
- Reset mid-frame aborts the frame. The line returns to idle-high at once.
- Handshake:
  - In IDLE, i_start=1 latches i_data_a, i_data_b and {zero pad, i_operation} into internal registers.
  - o_busy=1 from the next cycle until the cycle after o_done.
  - i_start while busy is ignored. Input changes after the latch cycle have no effect.
- Byte order on o_tx is fixed: A, B, OP. Frames are back-to-back with no idle gap.
- Frame format: start bit (0, 16 ticks), DBIT data bits LSB first (16 ticks each), stop bit (1, SB_TICK ticks).
- All bit timing advances only on i_s_tick cycles.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE.
- TX_STOP end with byte index < 2: increment the index and go to TX_START. With byte index = 2: go to RX_WAIT.
- The receiver is ignored outside the RX_* states and RX_WAIT. Activity on i_rx during transmission is discarded.
- i_rx is passed through a 2-flop synchronizer before use.
- RX_WAIT: synchronized i_rx=0 goes to RX_START, tick count reset.
- RX_START: at tick 7, if i_rx=0 go to RX_DATA (count reset). If i_rx=1, treat as a glitch and return to RX_WAIT.
- RX_DATA: sample at every 16th tick, shift in LSB first, DBIT samples.
- RX_STOP: after SB_TICK ticks go to DONE. The stop-bit value is not checked.
- DONE: lasts one cycle. o_result is loaded with the shift register, o_done=1, o_timeout=0. Then go to IDLE.
- Latency with i_s_tick tied high: A/B/OP transmission = 3*(16*(DBIT+1)+SB_TICK) cycles. o_done follows 1 cycle after the result stop period ends.
- An i_start in the same cycle as o_done is ignored, because o_busy is still 1.

Optional Feature:
- Macro: ALU_UART_TIMEOUT_EN.
- Defined:
  - A TO_BITS counter clears on RX_WAIT entry and counts i_s_tick while in RX_WAIT.
  - On reaching TIMEOUT_TICKS-1 without a start bit, go to DONE with o_timeout=1. o_result keeps its previous value.
  - A glitch returning from RX_START does not clear the counter.
- Not defined: no counter is built, o_timeout is tied 0, and RX_WAIT waits indefinitely.

Test Plan:
- Loopback to device model, i_s_tick=1 every cycle, A=0x05, B=0x03, op=0x20 -> o_tx carries frames 0x05, 0x03, 0x20 in order, each 160 cycles. Model replies 0x08 -> one o_done pulse, o_result=0x08, o_timeout=0.
- i_start pulsed again at 50 cycles into the first frame with A=0xFF -> ignored. Frame stream unchanged; exactly one o_done.
- Reply 0xA5 with a 3-tick low glitch on i_rx in RX_WAIT before the real frame -> glitch rejected, o_result=0xA5.
- i_reset low for 1 cycle during the second frame -> o_tx=1 and o_busy=0 immediately. A new command afterwards completes normally with the correct result.
- With ALU_UART_TIMEOUT_EN and TIMEOUT_TICKS=64, no reply -> o_done at 64 ticks after the OP stop bit, o_timeout=1, o_result keeps the prior value 0x08.
- i_s_tick every 4th cycle, A=0x80, B=0x01, op=0x22, reply 0x7F -> bit period 64 cycles on o_tx, o_result=0x7F.
